// File: rtl/qam16_mapper_if.sv
// QAM16 mapper bus: serial bit input handshake plus symbol-rate I/Q output.
// slave = mapper side, master = source/sink side.
interface qam16_mapper_if;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic [2:0] di;
  logic [2:0] dq;
  logic       bitsync;
  logic       sym_valid;
  logic       underflow;

  modport slave (
    input  din, din_valid,
    output din_ready, di, dq,
    output bitsync, sym_valid, underflow
  );

  modport master (
    output din, din_valid,
    input  din_ready, di, dq,
    input  bitsync, sym_valid, underflow
  );
endinterface

// File: rtl/qam16_mapper.sv
// Transmit QAM16 mapper: packs serial bits into 4-bit symbols, Gray/differential
// quadrant coding, emits 3-bit I/Q levels once per CLK_PER_SYM with bitsync.
module qam16_mapper #(
  parameter int CLK_PER_SYM = 8,
  parameter bit ZERO_STUFF  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  qam16_mapper_if.slave bus
);

  localparam int CW = $clog2(CLK_PER_SYM);

  logic [CW-1:0] cnt_q;
  logic [3:0]    sr_q;
  logic [1:0]    bc_q;
  logic [3:0]    pend_q;
  logic          pend_full_q;
  logic [1:0]    qs_q;
  logic [2:0]    di_q, dq_q;
  logic          bitsync_q;
  logic          sym_valid_q;
  logic          underflow_q;

  logic          tick;
  logic          accept;
  logic          complete;
  logic [3:0]    sr_d;
  logic [1:0]    qs_d;
  logic [2:0]    bi, bq;
  logic [2:0]    di_d, dq_d;

  assign tick = (cnt_q == CW'(CLK_PER_SYM - 1));

  // 4th bit is held off only while pend is full and not drained this edge
  assign bus.din_ready = rst
    & ~((bc_q == 2'd3) & pend_full_q & ~tick);

  assign accept   = bus.din_valid & bus.din_ready;
  assign complete = accept & (bc_q == 2'd3);
  assign sr_d     = {sr_q[2:0], bus.din};

  // Gray dibit to quadrant step: 00->0 01->1 11->2 10->3
  assign qs_d = qs_q + {pend_q[3], pend_q[3] ^ pend_q[2]};

  assign bi = pend_q[0] ? 3'b011 : 3'b001;
  assign bq = pend_q[1] ? 3'b011 : 3'b001;

  // (I,Q) -> (-Q,I) per 90 degree CCW step
  always_comb begin
    di_d = bi;
    dq_d = bq;
    case (qs_d)
      2'd0: begin di_d = bi;      dq_d = bq;      end
      2'd1: begin di_d = 3'(-bq); dq_d = bi;      end
      2'd2: begin di_d = 3'(-bi); dq_d = 3'(-bq); end
      2'd3: begin di_d = bq;      dq_d = 3'(-bi); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      bc_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      qs_q        <= '0;
      di_q        <= '0;
      dq_q        <= '0;
      bitsync_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;

      if (accept) begin
        sr_q <= sr_d;
        bc_q <= bc_q + 2'd1;
      end

      if (tick) begin
        bitsync_q   <= 1'b1;
        sym_valid_q <= pend_full_q;
        underflow_q <= ~pend_full_q;
        pend_full_q <= 1'b0;
        if (pend_full_q) begin
          qs_q <= qs_d;
          di_q <= di_d;
          dq_q <= dq_d;
        end else begin
          di_q <= '0;
          dq_q <= '0;
        end
      end else begin
        bitsync_q   <= 1'b0;
        sym_valid_q <= 1'b0;
        underflow_q <= 1'b0;
        if (ZERO_STUFF) begin
          di_q <= '0;
          dq_q <= '0;
        end
      end

      // refill after the drain above, so a same-edge tick+fill works
      if (complete) begin
        pend_q      <= sr_d;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign bus.di        = di_q;
  assign bus.dq        = dq_q;
  assign bus.bitsync   = bitsync_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_qam16_mapper.sv
// Directed bench for qam16_mapper: ZERO_STUFF=1 main DUT plus a
// ZERO_STUFF=0 twin fed from the same stimulus.
module tb_qam16_mapper;

  localparam int CPS = 8;

  logic clk = 1'b0;
  logic rst;
  int   nasrt = 0;
  int   nfail = 0;
  time  last_bs = 0;

  always #5 clk = ~clk;

  qam16_mapper_if bus ();
  qam16_mapper_if bus0 ();

  assign bus0.din       = bus.din;
  assign bus0.din_valid = bus.din_valid;

  qam16_mapper #(.CLK_PER_SYM(CPS), .ZERO_STUFF(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  qam16_mapper #(.CLK_PER_SYM(CPS), .ZERO_STUFF(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit done = 0;
    bus.din       = b;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 4 * CPS && !done; i++) begin
      if (bus.din_ready) done = 1;
      step();
    end
    bus.din_valid = 1'b0;
    if (!done) chk("send_timeout", 8'd0, 8'd1);
  endtask

  task automatic send_sym(input logic [3:0] s);
    for (int k = 3; k >= 0; k--) send_bit(s[k]);
  endtask

  task automatic wait_bs();
    bit got = 0;
    for (int i = 0; i < 3 * CPS && !got; i++) begin
      if (bus.bitsync && $time != last_bs) begin
        got     = 1;
        last_bs = $time;
      end else begin
        step();
      end
    end
    if (!got) chk("bs_timeout", 8'd0, 8'd1);
  endtask

  task automatic chk_sym(input string tag, input logic [5:0] iq);
    wait_bs();
    chk({tag, "_iq"}, {2'b00, bus.di, bus.dq}, {2'b00, iq});
    chk({tag, "_flg"},
        {5'd0, bus.bitsync, bus.sym_valid, bus.underflow},
        8'b0000_0110);
  endtask

  initial begin
    int r[24];
    int s;
    bit stable;

    rst           = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    repeat (2) step();

    // outputs and din_ready low while in reset
    chk("rst_out",
        {2'b00, bus.bitsync, bus.sym_valid, bus.underflow,
         bus.din_ready, 2'b00}, 8'd0);
    chk("rst_iq", {2'b00, bus.di, bus.dq}, 8'd0);

    // 1: idle slots
    rst = 1'b1;
    #1;
    chk("idle_ready", {7'd0, bus.din_ready}, 8'd1);
    wait_bs();
    chk("idle_flg",
        {5'd0, bus.bitsync, bus.sym_valid, bus.underflow}, 8'b101);
    chk("idle_iq", {2'b00, bus.di, bus.dq}, 8'd0);

    // 2: 0000 -> (+1,+1), zero stuffing vs hold
    do_reset();
    send_sym(4'b0000);
    chk_sym("s0000", 6'b001_001);
    chk("zs0_iq", {2'b00, bus0.di, bus0.dq}, 8'b00_001_001);
    step();
    chk("zs1_clear", {2'b00, bus.di, bus.dq}, 8'd0);
    stable = 1;
    for (int i = 0; i < CPS - 2; i++) begin
      if ({bus0.di, bus0.dq} !== 6'b001_001) stable = 0;
      step();
    end
    chk("zs0_hold", {7'd0, stable}, 8'd1);

    // 3: differential rotation, qs 1 then 2
    do_reset();
    send_sym(4'b0100);
    send_sym(4'b0100);
    chk_sym("rot1", 6'b111_001);
    chk_sym("rot2", 6'b111_111);

    // 4: underflow slot keeps qs
    do_reset();
    send_sym(4'b0111);
    chk_sym("s0111", 6'b101_011);
    wait_bs();
    chk("uf_flg",
        {5'd0, bus.bitsync, bus.sym_valid, bus.underflow}, 8'b101);
    chk("uf_iq", {2'b00, bus.di, bus.dq}, 8'd0);
    send_sym(4'b0000);
    chk_sym("qs_held", 6'b111_001);

    // 5: continuous din_valid, back-pressure
    do_reset();
    bus.din       = 1'b0;
    bus.din_valid = 1'b1;
    #0;
    for (int k = 0; k < 24; k++) begin
      r[k] = int'(bus.din_ready);
      step();
    end
    bus.din_valid = 1'b0;
    s = 0;
    for (int k = 0; k < 7; k++) s += r[k];
    chk("bp_first7", 8'(s), 8'd7);
    chk("bp_stall", 8'(r[12]), 8'd0);
    s = 0;
    for (int k = 8; k < 16; k++) s += r[k];
    chk("bp_per_sym1", 8'(s), 8'd4);
    s = 0;
    for (int k = 16; k < 24; k++) s += r[k];
    chk("bp_per_sym2", 8'(s), 8'd4);

    // 6: reset mid-symbol after qs=3
    do_reset();
    send_sym(4'b1000);
    chk_sym("qs3", 6'b001_111);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {7'd0, bus.din_ready}, 8'd0);
    chk("mid_rst_iq", {2'b00, bus.di, bus.dq}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    send_sym(4'b0000);
    chk_sym("post_rst", 6'b001_001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
